seq_input_checker: RTL and testbench
====================================

SEQ_INPUT_CHECKER -- requirements
Module: seq_input_checker

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 250000, number of consecutive stable cycles (5 ms at 50 MHz) required to accept a key level change.
REQ-002 Parameter TIMEOUT_CYCLES, default 500000000, cycles allowed between accepted presses (used only with REQ-034 macro).
REQ-003 CLOCK_50  input  1  sole clock, all state on rising edge.
REQ-004 resetn  input  1  reset, asynchronous, active-low.
REQ-005 start  input  1  active-high pulse, begin checking a player entry.
REQ-006 seq_len  input  4  number of moves to check, 0..15, sampled on accepted start.
REQ-007 key_press  input  1  raw active-high enter key level (undebounced).
REQ-008 sw_move  input  4  player's move value from switches.
REQ-009 mem_addr  output  4  read address into the stored game sequence memory.
REQ-010 mem_data  input  4  sequence memory read data, valid exactly one cycle after mem_addr changes.
REQ-011 busy  output  1  high while a check is in progress.
REQ-012 done  output  1  one-cycle pulse when a check finishes.
REQ-013 pass  output  1  held high after a fully correct entry.
REQ-014 fail  output  1  held high after a wrong move or timeout.
REQ-015 move_num  output  4  index of the move currently awaited / count of correct moves.
REQ-016 expected  output  4  on fail, the correct move value at the failing index; else 0.
REQ-017 timeout  output  1  held high when fail was caused by timeout.

Function
REQ-018 States: IDLE, WAIT_PRESS, FETCH, COMPARE, PASS, FAIL.
REQ-019 mem_addr SHALL equal move_num combinationally at all times.
REQ-020 start in IDLE, PASS or FAIL: clear pass/fail/timeout/expected/move_num, latch seq_len, next state WAIT_PRESS, busy=1; seq_len=0 instead goes to PASS next cycle with no memory reads.
REQ-021 start while busy SHALL be ignored.
REQ-022 Debouncer: key_press stable high for DEBOUNCE_CYCLES consecutive cycles yields one accepted press on that cycle; no further press until key_press stable low for DEBOUNCE_CYCLES; glitches shorter than DEBOUNCE_CYCLES restart the count.
REQ-023 Debouncer runs in every state; accepted presses outside WAIT_PRESS are discarded.
REQ-024 Accepted press in WAIT_PRESS: latch sw_move same cycle, go to FETCH.
REQ-025 FETCH: one wait cycle for mem_data; then COMPARE.
REQ-026 COMPARE, latched move == mem_data: move_num increments; if new move_num == seq_len go PASS, else WAIT_PRESS.
REQ-027 COMPARE, mismatch: expected <= mem_data, move_num unchanged, go FAIL.
REQ-028 Entering PASS or FAIL: done=1 for exactly one cycle, busy=0, pass or fail set and held until next accepted start or reset.
REQ-029 PASS with seq_len=15: move_num SHALL read 15 (no wrap).
REQ-030 Press-to-done latency for final correct move: 3 cycles after accepted press (WAIT_PRESS->FETCH->COMPARE->PASS).

Reset
REQ-031 resetn low SHALL immediately force state IDLE and all outputs 0 (mem_addr 0), clear debouncer and timeout counters, regardless of state.
REQ-032 After resetn rises, a key already held high SHALL require a full DEBOUNCE_CYCLES before acceptance.
REQ-033 Reset mid-check discards progress; no done pulse is produced.

Configuration
REQ-034 Macro SEQ_INPUT_TIMEOUT_EN defined: a counter clears on start and each accepted press; reaching TIMEOUT_CYCLES in WAIT_PRESS goes FAIL with timeout=1, expected=mem_data at current move_num, done pulse; a press accepted on the same cycle as expiry wins.
REQ-035 Macro undefined: no timeout counter, timeout tied 0, WAIT_PRESS waits indefinitely.

Verification (DEBOUNCE_CYCLES=4, TIMEOUT_CYCLES=100)
REQ-036 Memory {3,7,1}, seq_len=3, presses with sw_move 3,7,1 -> pass=1, done one pulse, move_num=3, fail=0.
REQ-037 Memory {3,7,1}, presses 3,5 -> fail=1, expected=7, move_num=1, timeout=0.
REQ-038 key_press high 3 cycles then low, repeated -> no press accepted, move_num stays 0; high 4 cycles -> exactly one accept.
REQ-039 start during WAIT_PRESS and seq_len=0 start from IDLE -> first ignored; second gives pass=1 next cycle, no mem_addr change.
REQ-040 resetn low mid-check after 2 correct moves -> all outputs 0 asynchronously, no done pulse.
REQ-041 With SEQ_INPUT_TIMEOUT_EN, no press 100 cycles after start -> fail=1, timeout=1, done pulse; without macro -> busy stays 1.

Source files
------------

// File: rtl/seq_input_checker.sv
// Checks a player's debounced key entries against a stored move sequence.
// Optional inter-press timeout is compiled in with SEQ_INPUT_TIMEOUT_EN.
module seq_input_checker #(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int TIMEOUT_CYCLES  = 500000000
) (
  input  logic       CLOCK_50,
  input  logic       resetn,
  input  logic       start,
  input  logic [3:0] seq_len,
  input  logic       key_press,
  input  logic [3:0] sw_move,
  output logic [3:0] mem_addr,
  input  logic [3:0] mem_data,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic       fail,
  output logic [3:0] move_num,
  output logic [3:0] expected,
  output logic       timeout
);

  if (DEBOUNCE_CYCLES < 1 || TIMEOUT_CYCLES < 1) begin : g_bad_param
    $error("seq_input_checker: DEBOUNCE_CYCLES and TIMEOUT_CYCLES must be >= 1");
  end

  localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT_PRESS, S_FETCH, S_COMPARE, S_PASS, S_FAIL
  } state_t;

  state_t          state_q, state_d;
  logic [DB_W-1:0] db_cnt_q, db_cnt_d;
  logic            db_level_q, db_level_d;
  logic            press_acc;
  logic            to_expired;
  logic            busy_q, busy_d, done_q, done_d, pass_q, pass_d;
  logic            fail_q, fail_d, timeout_q, timeout_d;
  logic [3:0]      move_num_q, move_num_d, expected_q, expected_d;
  logic [3:0]      move_q, move_d, len_q, len_d;
  logic [3:0]      next_num;

  // Debouncer: a level flips only after DEBOUNCE_CYCLES consecutive differing samples.
  always_comb begin
    db_level_d = db_level_q;
    db_cnt_d   = '0;
    press_acc  = 1'b0;
    if (key_press != db_level_q) begin
      if (db_cnt_q == DB_LAST) begin
        db_level_d = key_press;
        press_acc  = key_press;
      end else begin
        db_cnt_d = db_cnt_q + 1'b1;
      end
    end
  end

`ifdef SEQ_INPUT_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  logic [TO_W-1:0] to_cnt_q, to_cnt_d;

  always_comb begin
    to_cnt_d = to_cnt_q;
    if ((start && !busy_q) || press_acc) begin
      to_cnt_d = '0;
    end else if (busy_q && to_cnt_q != TO_LAST) begin
      to_cnt_d = to_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) to_cnt_q <= '0;
    else         to_cnt_q <= to_cnt_d;
  end

  // A press on the expiry cycle is served first by the FSM priority below.
  assign to_expired = (state_q == S_WAIT_PRESS) && (to_cnt_q == TO_LAST);
`else
  assign to_expired = 1'b0;
`endif

  assign next_num = move_num_q + 4'd1;

  always_comb begin
    state_d    = state_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    pass_d     = pass_q;
    fail_d     = fail_q;
    timeout_d  = timeout_q;
    move_num_d = move_num_q;
    expected_d = expected_q;
    move_d     = move_q;
    len_d      = len_q;
    case (state_q)
      S_IDLE, S_PASS, S_FAIL: begin
        if (start) begin
          pass_d     = 1'b0;
          fail_d     = 1'b0;
          timeout_d  = 1'b0;
          expected_d = '0;
          move_num_d = '0;
          len_d      = seq_len;
          if (seq_len == 4'd0) begin
            state_d = S_PASS;
            pass_d  = 1'b1;
            done_d  = 1'b1;
          end else begin
            state_d = S_WAIT_PRESS;
            busy_d  = 1'b1;
          end
        end
      end
      S_WAIT_PRESS: begin
        if (press_acc) begin
          move_d  = sw_move;
          state_d = S_FETCH;
        end else if (to_expired) begin
          state_d    = S_FAIL;
          busy_d     = 1'b0;
          done_d     = 1'b1;
          fail_d     = 1'b1;
          timeout_d  = 1'b1;
          expected_d = mem_data;
        end
      end
      S_FETCH: state_d = S_COMPARE;
      S_COMPARE: begin
        if (move_q == mem_data) begin
          move_num_d = next_num;
          if (next_num == len_q) begin
            state_d = S_PASS;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            pass_d  = 1'b1;
          end else begin
            state_d = S_WAIT_PRESS;
          end
        end else begin
          state_d    = S_FAIL;
          busy_d     = 1'b0;
          done_d     = 1'b1;
          fail_d     = 1'b1;
          expected_d = mem_data;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      state_q    <= S_IDLE;
      db_cnt_q   <= '0;
      db_level_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
      fail_q     <= 1'b0;
      timeout_q  <= 1'b0;
      move_num_q <= '0;
      expected_q <= '0;
    end else begin
      state_q    <= state_d;
      db_cnt_q   <= db_cnt_d;
      db_level_q <= db_level_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      pass_q     <= pass_d;
      fail_q     <= fail_d;
      timeout_q  <= timeout_d;
      move_num_q <= move_num_d;
      expected_q <= expected_d;
    end
  end

  // Latched move and length are only read while busy, so they need no reset.
  always_ff @(posedge CLOCK_50) begin
    move_q <= move_d;
    len_q  <= len_d;
  end

  assign mem_addr = move_num_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign pass     = pass_q;
  assign fail     = fail_q;
  assign move_num = move_num_q;
  assign expected = expected_q;
  assign timeout  = timeout_q;

endmodule

// File: tb/tb_seq_input_checker.sv
// Scoreboard bench for seq_input_checker (DEBOUNCE_CYCLES=4, TIMEOUT_CYCLES=100).
module tb_seq_input_checker;

  logic       CLOCK_50 = 1'b0;
  logic       resetn = 1'b1;
  logic       start = 1'b0;
  logic [3:0] seq_len = '0;
  logic       key_press = 1'b0;
  logic [3:0] sw_move = '0;
  logic [3:0] mem_addr;
  logic [3:0] mem_data = '0;
  logic       busy, done, pass, fail, timeout;
  logic [3:0] move_num, expected;

  logic [3:0] mem [16];

  typedef struct packed {
    logic       pass;
    logic       fail;
    logic [3:0] move_num;
    logic [3:0] expected;
    logic       timeout;
  } result_t;

  result_t sb[$];
  int      n_checks = 0;
  int      n_fail   = 0;
  logic    done_prev = 1'b0;

  seq_input_checker #(.DEBOUNCE_CYCLES(4), .TIMEOUT_CYCLES(100)) dut (
    .CLOCK_50 (CLOCK_50),
    .resetn   (resetn),
    .start    (start),
    .seq_len  (seq_len),
    .key_press(key_press),
    .sw_move  (sw_move),
    .mem_addr (mem_addr),
    .mem_data (mem_data),
    .busy     (busy),
    .done     (done),
    .pass     (pass),
    .fail     (fail),
    .move_num (move_num),
    .expected (expected),
    .timeout  (timeout)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  // Synchronous sequence memory: data valid one cycle after the address.
  always @(posedge CLOCK_50) mem_data <= mem[mem_addr];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
    end
  endtask

  always @(negedge CLOCK_50) begin
    if (done === 1'b1) begin
      check("done_width", done_prev, 0);
      if (sb.size() == 0) begin
        check("unexpected_done", done, 0);
      end else begin
        result_t e;
        e = sb.pop_front();
        check("sb_pass", pass, e.pass);
        check("sb_fail", fail, e.fail);
        check("sb_move_num", move_num, e.move_num);
        check("sb_expected", expected, e.expected);
        check("sb_timeout", timeout, e.timeout);
        check("sb_busy", busy, 0);
      end
    end
    done_prev <= done;
  end

  task automatic do_start(input logic [3:0] n);
    @(posedge CLOCK_50); #1;
    start = 1'b1; seq_len = n;
    @(posedge CLOCK_50); #1;
    start = 1'b0;
  endtask

  task automatic press_hold(input logic [3:0] mv);
    @(posedge CLOCK_50); #1;
    sw_move = mv; key_press = 1'b1;
    repeat (4) @(posedge CLOCK_50);
    #1 key_press = 1'b0;
  endtask

  task automatic release_key();
    repeat (5) @(posedge CLOCK_50);
  endtask

  task automatic press(input logic [3:0] mv);
    press_hold(mv);
    release_key();
  endtask

  task automatic wait_done(input int budget);
    for (int i = 0; i < budget && busy; i++) @(negedge CLOCK_50);
    check("wait_budget", busy, 0);
  endtask

  task automatic pulse_reset();
    @(negedge CLOCK_50); #2 resetn = 1'b0;
    @(negedge CLOCK_50); resetn = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got running, want finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    mem[0] = 4'd3; mem[1] = 4'd7; mem[2] = 4'd1;
    for (int i = 3; i < 16; i++) mem[i] = 4'($urandom_range(0, 15));

    // Reset state.
    #1 resetn = 1'b0;
    #2;
    check("rst_busy", busy, 0);
    check("rst_pass", pass, 0);
    check("rst_fail", fail, 0);
    check("rst_move_num", move_num, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_done", done, 0);
    repeat (2) @(negedge CLOCK_50);
    resetn = 1'b1;

    // Fully correct entry, with press-to-done latency on the last move.
    sb.push_back('{pass: 1'b1, fail: 1'b0, move_num: 4'd3, expected: 4'd0, timeout: 1'b0});
    do_start(4'd3);
    check("t1_busy", busy, 1);
    press(4'd3);
    press(4'd7);
    check("t1_mem_addr", mem_addr, 2);
    press_hold(4'd1);
    @(negedge CLOCK_50); check("t1_lat_fetch", done, 0);
    @(negedge CLOCK_50); check("t1_lat_compare", done, 0);
    @(negedge CLOCK_50); check("t1_lat_done", done, 1);
    @(negedge CLOCK_50); check("t1_done_low", done, 0);
    check("t1_pass_held", pass, 1);
    release_key();

    // Wrong second move.
    sb.push_back('{pass: 1'b0, fail: 1'b1, move_num: 4'd1, expected: 4'd7, timeout: 1'b0});
    do_start(4'd3);
    check("t2_pass_cleared", pass, 0);
    press(4'd3);
    press(4'd5);
    wait_done(20);
    check("t2_fail_held", fail, 1);

    // Short glitches are rejected; a long hold is accepted exactly once.
    do_start(4'd3);
    sw_move = 4'd3;
    for (int g = 0; g < 3; g++) begin
      @(posedge CLOCK_50); #1 key_press = 1'b1;
      repeat (3) @(posedge CLOCK_50);
      #1 key_press = 1'b0;
      repeat (2) @(posedge CLOCK_50);
    end
    @(negedge CLOCK_50);
    check("t3_glitch_move_num", move_num, 0);
    check("t3_glitch_busy", busy, 1);
    @(posedge CLOCK_50); #1 key_press = 1'b1;
    repeat (12) @(posedge CLOCK_50);
    #1 key_press = 1'b0;
    release_key();
    @(negedge CLOCK_50);
    check("t3_one_accept", move_num, 1);
    check("t3_no_fail", fail, 0);
    press(4'd7);
    @(negedge CLOCK_50);
    check("t3_two_correct", move_num, 2);

    // Start while busy is ignored.
    do_start(4'd0);
    @(negedge CLOCK_50);
    check("t4_ignored_busy", busy, 1);
    check("t4_ignored_pass", pass, 0);
    check("t4_ignored_move", move_num, 2);

    // Asynchronous reset mid-check: outputs clear before any clock edge.
    @(negedge CLOCK_50); #2 resetn = 1'b0;
    #1;
    check("t5_busy", busy, 0);
    check("t5_move_num", move_num, 0);
    check("t5_mem_addr", mem_addr, 0);
    check("t5_pass", pass, 0);
    check("t5_fail", fail, 0);
    check("t5_expected", expected, 0);
    check("t5_timeout", timeout, 0);
    repeat (3) @(negedge CLOCK_50);
    resetn = 1'b1;
    repeat (3) @(negedge CLOCK_50);
    check("t5_no_done", done, 0);

    // Zero-length entry from IDLE passes on the next cycle without reads.
    sb.push_back('{pass: 1'b1, fail: 1'b0, move_num: 4'd0, expected: 4'd0, timeout: 1'b0});
    do_start(4'd0);
    @(negedge CLOCK_50);
    check("t6_pass", pass, 1);
    check("t6_mem_addr", mem_addr, 0);
    @(negedge CLOCK_50);
    check("t6_done_low", done, 0);

    // Longest entry: move_num reaches 15 without wrapping.
    sb.push_back('{pass: 1'b1, fail: 1'b0, move_num: 4'd15, expected: 4'd0, timeout: 1'b0});
    do_start(4'd15);
    for (int i = 0; i < 15; i++) press(mem[i]);
    wait_done(20);
    check("t7_move_num", move_num, 15);
    check("t7_mem_addr", mem_addr, 15);

    // No presses after start.
`ifdef SEQ_INPUT_TIMEOUT_EN
    sb.push_back('{pass: 1'b0, fail: 1'b1, move_num: 4'd0, expected: 4'd3, timeout: 1'b1});
    do_start(4'd3);
    wait_done(150);
    check("t8_timeout", timeout, 1);
`else
    do_start(4'd3);
    repeat (150) @(negedge CLOCK_50);
    check("t8_busy_waits", busy, 1);
    check("t8_no_fail", fail, 0);
    check("t8_timeout_tied", timeout, 0);
    pulse_reset();
`endif

    repeat (3) @(negedge CLOCK_50);
    check("sb_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
